// File: rtl/noc_params.sv
// Shared router constants and types used by the allocator and its arbiters.
package noc_params;
    localparam int INPUT_NUM  = 4;
    localparam int OUTPUT_NUM = 4;
    localparam int VC_NUM     = 2;
    localparam int SEL_SIZE   = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;
    localparam int OUT_SIZE   = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1;
    localparam int VC_SIZE    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef logic [OUT_SIZE-1:0] port_t;
endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: priority starts at ptr and rotates; ptr moves past the
// winner only on cycles where update is asserted and a grant was issued.
module round_robin_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] request,
    input  logic         update,
    output logic [N-1:0] grant
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] ptr;
    logic [W-1:0] ptr_next;
    logic [W-1:0] idx;
    logic         found;

    always_comb begin
        grant    = '0;
        found    = 1'b0;
        ptr_next = ptr;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            idx = W'((int'(ptr) + k) % N);
            if (!found && request[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_next   = W'((int'(idx) + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (update && found) begin
            ptr <= ptr_next;
        end
    end
endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator: per-input VC arbitration, then
// per-output input arbitration; crossbar controls and pops are registered.
module switch_allocator
    import noc_params::*;
#(
    parameter int INPUT_NUM  = noc_params::INPUT_NUM,
    parameter int OUTPUT_NUM = noc_params::OUTPUT_NUM,
    parameter int VC_NUM     = noc_params::VC_NUM,
    parameter int SEL_SIZE   = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1,
    parameter int OUT_SIZE   = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1,
    parameter int VC_SIZE    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [INPUT_NUM-1:0][VC_NUM-1:0]               request_i,
    input  logic [INPUT_NUM-1:0][VC_NUM-1:0][OUT_SIZE-1:0] out_port_i,
    input  logic [INPUT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]  downstream_vc_i,
    input  logic [OUTPUT_NUM-1:0][VC_NUM-1:0]              credit_avail_i,
    output logic [INPUT_NUM-1:0][VC_NUM-1:0]               grant_o,
    output logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]            sel_o,
    output logic [OUTPUT_NUM-1:0]                          valid_o
);
    logic [INPUT_NUM-1:0][VC_NUM-1:0]      eligible;
    logic [INPUT_NUM-1:0][VC_NUM-1:0]      s1_grant;
    logic [INPUT_NUM-1:0]                  s1_valid;
    logic [INPUT_NUM-1:0][OUT_SIZE-1:0]    s1_port;
    logic [OUTPUT_NUM-1:0][INPUT_NUM-1:0]  s2_req;
    logic [OUTPUT_NUM-1:0][INPUT_NUM-1:0]  s2_grant;
    logic [INPUT_NUM-1:0]                  input_won;
    logic [INPUT_NUM-1:0][VC_NUM-1:0]      grant_next;
    logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]   sel_next;
    logic [OUTPUT_NUM-1:0]                 valid_next;

    // An out-of-range port behaves as no request; its credit is never looked up.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < INPUT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (request_i[i][v] && (int'(out_port_i[i][v]) < OUTPUT_NUM)) begin
                    eligible[i][v] = credit_avail_i[out_port_i[i][v]][downstream_vc_i[i][v]];
                end
            end
        end
    end

    for (genvar gi = 0; gi < INPUT_NUM; gi++) begin : g_stage1
        round_robin_arbiter #(.N(VC_NUM)) u_vc_arb (
            .clk     (clk),
            .rst     (rst),
            .request (eligible[gi]),
            .update  (input_won[gi]),
            .grant   (s1_grant[gi])
        );
    end

    always_comb begin
        s1_valid = '0;
        s1_port  = '0;
        s2_req   = '0;
        for (int i = 0; i < INPUT_NUM; i++) begin
            s1_valid[i] = |s1_grant[i];
            for (int v = 0; v < VC_NUM; v++) begin
                if (s1_grant[i][v]) begin
                    s1_port[i] = out_port_i[i][v];
                end
            end
            for (int o = 0; o < OUTPUT_NUM; o++) begin
                s2_req[o][i] = s1_valid[i] && (int'(s1_port[i]) == o);
            end
        end
    end

    for (genvar go = 0; go < OUTPUT_NUM; go++) begin : g_stage2
        round_robin_arbiter #(.N(INPUT_NUM)) u_in_arb (
            .clk     (clk),
            .rst     (rst),
            .request (s2_req[go]),
            .update  (1'b1),
            .grant   (s2_grant[go])
        );
    end

    // Stage-1 winners that lose stage 2 get no pop and keep their VC pointer.
    always_comb begin
        input_won  = '0;
        grant_next = '0;
        sel_next   = '0;
        valid_next = '0;
        for (int o = 0; o < OUTPUT_NUM; o++) begin
            valid_next[o] = |s2_grant[o];
            for (int i = 0; i < INPUT_NUM; i++) begin
                if (s2_grant[o][i]) begin
                    sel_next[o]  = SEL_SIZE'(i);
                    input_won[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < INPUT_NUM; i++) begin
            grant_next[i] = input_won[i] ? s1_grant[i] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_o <= '0;
            sel_o   <= '0;
            valid_o <= '0;
        end else begin
            grant_o <= grant_next;
            sel_o   <= sel_next;
            valid_o <= valid_next;
        end
    end
endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios plus random traffic checked
// against a priority-list allocation model.
module tb_switch_allocator;
    import noc_params::*;

    localparam int NI = 4;
    localparam int NO = 4;
    localparam int NV = 2;

    logic clk;
    logic rst;
    logic [NI-1:0][NV-1:0]            request;
    logic [NI-1:0][NV-1:0][1:0]       out_port;
    logic [NI-1:0][NV-1:0][0:0]       dvc;
    logic [NO-1:0][NV-1:0]            credit;
    logic [NI-1:0][NV-1:0]            grant;
    logic [NO-1:0][1:0]               sel;
    logic [NO-1:0]                    valid;

    logic [NI-1:0][NV-1:0] exp_grant;
    logic [NO-1:0][1:0]    exp_sel;
    logic [NO-1:0]         exp_valid;
    logic [1:0]            exp_q[$];

    int m_in_ptr[NI];
    int m_out_ptr[NO];
    int n_checks;
    int n_errors;

    switch_allocator dut (
        .clk             (clk),
        .rst             (rst),
        .request_i       (request),
        .out_port_i      (out_port),
        .downstream_vc_i (dvc),
        .credit_avail_i  (credit),
        .grant_o         (grant),
        .sel_o           (sel),
        .valid_o         (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        request  = '0;
        out_port = '0;
        dvc      = '0;
        credit   = '1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) m_in_ptr[i] = 0;
        for (int o = 0; o < NO; o++) m_out_ptr[o] = 0;
    endtask

    // Model: each input lists its eligible VCs starting at its pointer and
    // takes the first; each output scans inputs from its pointer for the
    // first one whose chosen VC targets it. Then one clock edge passes.
    task automatic advance();
        int   w1[NI];
        int   new_in[NI];
        int   new_out[NO];
        port_t p;
        exp_grant = '0;
        exp_sel   = '0;
        exp_valid = '0;
        for (int i = 0; i < NI; i++) begin
            w1[i] = -1;
            new_in[i] = m_in_ptr[i];
            for (int k = 0; k < NV; k++) begin
                int v;
                v = (m_in_ptr[i] + k) % NV;
                p = out_port[i][v];
                if (w1[i] < 0 && request[i][v] && int'(p) < NO && credit[p][dvc[i][v]])
                    w1[i] = v;
            end
        end
        for (int o = 0; o < NO; o++) begin
            new_out[o] = m_out_ptr[o];
            for (int k = 0; k < NI; k++) begin
                int i;
                i = (m_out_ptr[o] + k) % NI;
                if (!exp_valid[o] && w1[i] >= 0 && int'(out_port[i][w1[i]]) == o) begin
                    exp_valid[o]       = 1'b1;
                    exp_sel[o]         = 2'(i);
                    exp_grant[i][w1[i]] = 1'b1;
                    new_out[o]         = (i + 1) % NI;
                    new_in[i]          = (w1[i] + 1) % NV;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) m_in_ptr[i] = new_in[i];
        for (int o = 0; o < NO; o++) m_out_ptr[o] = new_out[o];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if (grant !== '0) begin
            n_errors++;
            $display("FAIL reset_grant: got %h expected 0", grant);
        end
        n_checks++;
        if (valid !== '0) begin
            n_errors++;
            $display("FAIL reset_valid: got %b expected 0", valid);
        end
        n_checks++;
        if (sel !== '0) begin
            n_errors++;
            $display("FAIL reset_sel: got %h expected 0", sel);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        clear_inputs();
        request[2][1]  = 1'b1;
        out_port[2][1] = 2'd3;
        dvc[2][1]      = 1'b0;
        advance();
        n_checks++;
        if (grant !== 8'b0010_0000) begin
            n_errors++;
            $display("FAIL single_grant: got %b expected 00100000", grant);
        end
        n_checks++;
        if (valid !== 4'b1000 || sel[3] !== 2'd2) begin
            n_errors++;
            $display("FAIL single_xbar: got valid=%b sel3=%0d expected valid=1000 sel3=2", valid, sel[3]);
        end
        clear_inputs();
        advance();
        n_checks++;
        if (grant !== '0 || valid !== '0 || sel !== '0) begin
            n_errors++;
            $display("FAIL single_idle: got grant=%b valid=%b sel=%h expected all 0", grant, valid, sel);
        end
    endtask

    task automatic start_contention();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            request[i][0]  = 1'b1;
            out_port[i][0] = 2'd1;
        end
    endtask

    task automatic test_contention();
        logic [1:0] want;
        int granted[NI];
        for (int i = 0; i < NI; i++) granted[i] = 0;
        start_contention();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 3; i++) exp_q.push_back(2'(i));
        for (int c = 0; c < 6; c++) begin
            advance();
            want = exp_q.pop_front();
            for (int i = 0; i < NI; i++) if (grant[i][0]) granted[i]++;
            n_checks++;
            if (valid[1] !== 1'b1 || sel[1] !== want) begin
                n_errors++;
                $display("FAIL contention_seq: cycle %0d got valid1=%b sel1=%0d expected valid1=1 sel1=%0d", c, valid[1], sel[1], want);
            end
            n_checks++;
            if (grant !== exp_grant) begin
                n_errors++;
                $display("FAIL contention_grant: cycle %0d got %b expected %b", c, grant, exp_grant);
            end
        end
        n_checks++;
        if (granted[0] != 2 || granted[1] != 2 || granted[2] != 2 || granted[3] != 0) begin
            n_errors++;
            $display("FAIL contention_share: got %0d %0d %0d %0d expected 2 2 2 0", granted[0], granted[1], granted[2], granted[3]);
        end
    endtask

    task automatic test_vc_fairness();
        int last_vc;
        clear_inputs();
        request[0]     = 2'b11;
        out_port[0][0] = 2'd0;
        out_port[0][1] = 2'd2;
        last_vc = -1;
        for (int c = 0; c < 6; c++) begin
            int this_vc;
            advance();
            this_vc = grant[0][1] ? 1 : 0;
            n_checks++;
            if (grant !== exp_grant || valid !== exp_valid || sel !== exp_sel) begin
                n_errors++;
                $display("FAIL vc_model: cycle %0d got grant=%b valid=%b expected grant=%b valid=%b", c, grant, valid, exp_grant, exp_valid);
            end
            n_checks++;
            if ($countones(grant[0]) != 1 || this_vc == last_vc ||
                valid !== (this_vc == 1 ? 4'b0100 : 4'b0001)) begin
                n_errors++;
                $display("FAIL vc_alternate: cycle %0d got grant0=%b valid=%b prev_vc=%0d", c, grant[0], valid, last_vc);
            end
            last_vc = this_vc;
        end
    endtask

    task automatic test_credit_block();
        clear_inputs();
        request[1][0]  = 1'b1;
        out_port[1][0] = 2'd2;
        dvc[1][0]      = 1'b1;
        credit[2][1]   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            advance();
            n_checks++;
            if (grant !== '0 || valid[2] !== 1'b0) begin
                n_errors++;
                $display("FAIL credit_blocked: cycle %0d got grant=%b valid=%b expected none", c, grant, valid);
            end
        end
        credit[2][1] = 1'b1;
        advance();
        n_checks++;
        if (grant[1][0] !== 1'b1 || valid !== 4'b0100 || sel[2] !== 2'd1) begin
            n_errors++;
            $display("FAIL credit_release: got grant=%b valid=%b sel2=%0d expected grant10=1 valid=0100 sel2=1", grant, valid, sel[2]);
        end
        request[1][0] = 1'b1;
        credit[2][1]  = 1'b0;
        advance();
        n_checks++;
        if (grant !== '0 || valid !== '0) begin
            n_errors++;
            $display("FAIL credit_drop: got grant=%b valid=%b expected 0", grant, valid);
        end
    endtask

    task automatic test_parallel();
        clear_inputs();
        for (int i = 0; i < NI; i++) begin
            request[i][0]  = 1'b1;
            out_port[i][0] = 2'(3 - i);
        end
        advance();
        n_checks++;
        if (valid !== 4'b1111 || sel !== 8'b00_01_10_11) begin
            n_errors++;
            $display("FAIL parallel: got valid=%b sel=%b expected 1111 00011011", valid, sel);
        end
        n_checks++;
        if (grant !== 8'b01_01_01_01) begin
            n_errors++;
            $display("FAIL parallel_grant: got %b expected 01010101", grant);
        end
    endtask

    task automatic test_reset_mid();
        start_contention();
        for (int c = 0; c < 4; c++) advance();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (grant !== '0 || valid !== '0 || sel !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_async: got grant=%b valid=%b sel=%h expected all 0", grant, valid, sel);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        advance();
        n_checks++;
        if (valid[1] !== 1'b1 || sel[1] !== 2'd0 || grant[0][0] !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_first: got valid1=%b sel1=%0d grant=%b expected input 0", valid[1], sel[1], grant);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            request  = NI * NV'($urandom);
            for (int i = 0; i < NI; i++) begin
                request[i] = 2'($urandom_range(0, 3));
                for (int v = 0; v < NV; v++) begin
                    out_port[i][v] = 2'($urandom_range(0, 3));
                    dvc[i][v]      = 1'($urandom_range(0, 1));
                end
            end
            for (int o = 0; o < NO; o++) credit[o] = 2'($urandom_range(0, 3));
            advance();
            n_checks++;
            if (grant !== exp_grant || valid !== exp_valid || sel !== exp_sel) begin
                n_errors++;
                $display("FAIL random: cycle %0d got grant=%b valid=%b sel=%h expected grant=%b valid=%b sel=%h",
                         c, grant, valid, sel, exp_grant, exp_valid, exp_sel);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_single();
        test_contention();
        test_vc_fairness();
        test_credit_block();
        test_parallel();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
